add_seq_n: RTL and testbench

- Multi-cycle sequential adder. Computes the exact (N+1)-bit sum of two N-bit operands, K bits per clock, through a ripple slice with a registered carry.
- Companion to the subtractor in the arithmetic library. Its outputs use the same {over_o, data_o} = (N+1)-bit result convention.
- Sits between operand producers and consumers that use valid/ready handshakes. Trades latency for a narrow K-bit carry chain.

---
 rtl/add_seq_n.sv | 118 +++++++++++
 tb/tb_add_seq_n.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/add_seq_n.sv
// Multi-cycle adder: exact (N+1)-bit sum of two N-bit operands, K bits per clock, valid/ready at both ends.
// Latency N/K edges from accept to valid_o; ready_o only in IDLE. Define ADD_SEQ_SUB_EN to add op_i (1 = subtract).
module add_seq_n #(
   parameter int N = 8,
   parameter int K = 2
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         sign_i,
`ifdef ADD_SEQ_SUB_EN
   input  logic         op_i,
`endif
   input  logic [N-1:0] data0_i,
   input  logic [N-1:0] data1_i,
   input  logic         valid_i,
   output logic         ready_o,
   output logic [N-1:0] data_o,
   output logic         over_o,
   output logic         valid_o,
   input  logic         ready_i
);

   localparam int S  = N / K;
   localparam int CW = (S > 1) ? $clog2(S) : 1;

   generate
      if ((N % K) != 0 || N < 2 || K < 1) begin : g_bad_params
         $error("add_seq_n: N must be >= 2 and a multiple of K");
      end
   endgenerate

   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

   state_t          r_state;
   state_t          w_next;
   logic [N-1:0]    r_a;
   logic [N-1:0]    r_b;
   logic [N-1:0]    r_res;
   logic            r_ext0;
   logic            r_ext1;
   logic            r_carry;
   logic            r_over;
   logic [CW-1:0]   r_cnt;

   logic            w_accept;
   logic            w_sub;
   logic            w_last;
   logic [K-1:0]    w_a_sl;
   logic [K-1:0]    w_b_sl;
   logic [K:0]      w_sum;

`ifdef ADD_SEQ_SUB_EN
   assign w_sub = op_i;
`else
   assign w_sub = 1'b0;
`endif

   assign w_accept = valid_i && (r_state == IDLE);
   assign w_last   = (r_cnt == CW'(S - 1));
   assign w_a_sl   = r_a[r_cnt*K +: K];
   assign w_b_sl   = r_b[r_cnt*K +: K];
   assign w_sum    = {1'b0, w_a_sl} + {1'b0, w_b_sl} + {{K{1'b0}}, r_carry};

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (valid_i) w_next = RUN;
         RUN:     if (w_last)  w_next = DONE;
         DONE:    if (ready_i) w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_comb begin
      ready_o = (r_state == IDLE);
      valid_o = (r_state == DONE);
   end

   // Subtraction folds into the add path: invert B and its extension bit, seed carry with 1.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_a     <= '0;
         r_b     <= '0;
         r_res   <= '0;
         r_ext0  <= 1'b0;
         r_ext1  <= 1'b0;
         r_carry <= 1'b0;
         r_over  <= 1'b0;
         r_cnt   <= '0;
      end else if (w_accept) begin
         r_a     <= data0_i;
         r_b     <= data1_i ^ {N{w_sub}};
         r_ext0  <= sign_i & data0_i[N-1];
         r_ext1  <= (sign_i & data1_i[N-1]) ^ w_sub;
         r_carry <= w_sub;
         r_cnt   <= '0;
      end else if (r_state == RUN) begin
         r_res[r_cnt*K +: K] <= w_sum[K-1:0];
         r_carry             <= w_sum[K];
         r_cnt               <= r_cnt + CW'(1);
         if (w_last) begin
            r_over <= r_ext0 ^ r_ext1 ^ w_sum[K];
         end
      end
   end

   assign data_o = r_res;
   assign over_o = r_over;

endmodule

// File: tb/tb_add_seq_n.sv
// Directed bench for add_seq_n (N=8, K=2): sums, latency, backpressure, reset abort, optional subtract.
module tb_add_seq_n;

   logic       clk_i = 1'b0;
   logic       rst_ni = 1'b0;
   logic       sign_i = 1'b0;
   logic [7:0] data0_i = 8'h00;
   logic [7:0] data1_i = 8'h00;
   logic       valid_i = 1'b0;
   logic       ready_o;
   logic [7:0] data_o;
   logic       over_o;
   logic       valid_o;
   logic       ready_i = 1'b0;
`ifdef ADD_SEQ_SUB_EN
   logic       op_i = 1'b0;
`endif

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk_i = ~clk_i;

   add_seq_n #(.N(8), .K(2)) dut (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .sign_i  (sign_i),
`ifdef ADD_SEQ_SUB_EN
      .op_i    (op_i),
`endif
      .data0_i (data0_i),
      .data1_i (data1_i),
      .valid_i (valid_i),
      .ready_o (ready_o),
      .data_o  (data_o),
      .over_o  (over_o),
      .valid_o (valid_o),
      .ready_i (ready_i)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Launch one operation, wait (bounded) for valid_o, return result and edge count from accept.
   task automatic start_op(input logic [7:0] a, input logic [7:0] b, input logic s,
                           output logic [8:0] res, output int lat);
      @(negedge clk_i);
      data0_i = a;
      data1_i = b;
      sign_i  = s;
      valid_i = 1'b1;
      @(posedge clk_i);
      #1;
      valid_i = 1'b0;
      data0_i = 8'hA5;
      data1_i = 8'h5A;
      lat = 0;
      while (!valid_o && lat < 20) begin
         @(posedge clk_i);
         #1;
         lat++;
      end
      res = {over_o, data_o};
   endtask

   task automatic release_result();
      @(negedge clk_i);
      ready_i = 1'b1;
      @(posedge clk_i);
      #1;
      ready_i = 1'b0;
   endtask

   task automatic op_check(input string tag, input logic [7:0] a, input logic [7:0] b,
                           input logic s, input logic [8:0] exp);
      logic [8:0] res;
      int         lat;
      start_op(a, b, s, res, lat);
      check({tag, "_lat"}, lat, 4);
      check({tag, "_res"}, res, exp);
      release_result();
      check({tag, "_idle"}, {valid_o, ready_o}, 2'b01);
   endtask

   initial begin
      logic [8:0] res;
      int         lat;

      #12;
      check("rst_outputs", {ready_o, valid_o, over_o, data_o}, {1'b1, 1'b0, 1'b0, 8'h00});
      @(negedge clk_i);
      rst_ni = 1'b1;

      op_check("u_ovf",   8'hC8, 8'h64, 1'b0, 9'h12C);
      op_check("s_neg",   8'h9C, 8'h9C, 1'b1, 9'h138);
      op_check("s_pos",   8'h64, 8'h1B, 1'b1, 9'h07F);
      op_check("u_wrap",  8'hFF, 8'h01, 1'b0, 9'h100);
      op_check("s_m1p1",  8'hFF, 8'h01, 1'b1, 9'h000);
      op_check("s_128",   8'h7F, 8'h01, 1'b1, 9'h080);
      op_check("u_zero",  8'h00, 8'h00, 1'b0, 9'h000);

      // Backpressure: hold ready_i low in DONE and poke valid_i with other operands.
      start_op(8'h12, 8'h34, 1'b0, res, lat);
      check("bp_lat", lat, 4);
      check("bp_res", res, 9'h046);
      @(negedge clk_i);
      valid_i = 1'b1;
      data0_i = 8'hFF;
      data1_i = 8'hFF;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk_i);
         #1;
         check("bp_hold", {valid_o, ready_o, over_o, data_o}, {1'b1, 1'b0, 1'b0, 8'h46});
      end
      valid_i = 1'b0;
      release_result();
      check("bp_release", {valid_o, ready_o}, 2'b01);
      check("bp_no_queue", valid_o, 1'b0);

      // Reset after two slices of a RUN aborts and clears outputs.
      @(negedge clk_i);
      data0_i = 8'hFF;
      data1_i = 8'hFF;
      sign_i  = 1'b0;
      valid_i = 1'b1;
      @(posedge clk_i);
      #1;
      valid_i = 1'b0;
      @(posedge clk_i);
      @(posedge clk_i);
      #1;
      check("mid_run_partial", {ready_o, valid_o, data_o[3:0]}, {1'b0, 1'b0, 4'hE});
      #2;
      rst_ni = 1'b0;
      #1;
      check("mid_run_rst", {ready_o, valid_o, over_o, data_o}, {1'b1, 1'b0, 1'b0, 8'h00});
      @(negedge clk_i);
      rst_ni = 1'b1;
      op_check("after_rst", 8'h01, 8'h01, 1'b0, 9'h002);

`ifdef ADD_SEQ_SUB_EN
      op_i = 1'b1;
      op_check("sub_5m7", 8'h05, 8'h07, 1'b0, 9'h1FE);
      op_check("sub_7m5", 8'h07, 8'h05, 1'b0, 9'h002);
      op_i = 1'b0;
      op_check("add_again", 8'h07, 8'h05, 1'b0, 9'h00C);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
